// File: rtl/mlp_host_loader_if.sv
// Byte-stream port between the host bridge and the MLP packet loader.
interface mlp_host_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       hold;

  modport master (output s_data, output s_valid, output hold, input s_ready);
  modport slave  (input s_data, input s_valid, input hold, output s_ready);
endinterface

// File: rtl/mlp_host_loader.sv
// Host packet loader: parses TARGET/ADDR/LEN framed packets from a byte
// stream and turns the payload into single-byte writes on the input, weight
// or bias memory ports.
module mlp_host_loader #(
  parameter int INPUT_DEPTH  = 4096,
  parameter int WEIGHT_DEPTH = 16384,
  parameter int BIAS_DEPTH   = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  mlp_host_loader_if.slave    s,
  output logic [15:0]         input_addr_o,
  output logic [7:0]          input_data_o,
  output logic                input_we_o,
  output logic [15:0]         weight_addr_o,
  output logic [7:0]          weight_data_o,
  output logic                weight_we_o,
  output logic [15:0]         bias_addr_o,
  output logic [7:0]          bias_data_o,
  output logic                bias_we_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_target_o,
  output logic                err_range_o,
  output logic [15:0]         pkt_count_o
);

  typedef enum logic [2:0] {IDLE, A_HI, A_LO, L_HI, L_LO, DATA} state_t;

  state_t      state_q, state_d;
  logic        ready_q;
  logic [1:0]  tgt_q, tgt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] in_addr_q, in_addr_d, wt_addr_q, wt_addr_d, bs_addr_q, bs_addr_d;
  logic [7:0]  in_data_q, in_data_d, wt_data_q, wt_data_d, bs_data_q, bs_data_d;
  logic        in_we_q, in_we_d, wt_we_q, wt_we_d, bs_we_q, bs_we_d;
  logic        done_q, done_d, err_t_q, err_t_d, err_r_q, err_r_d;
  logic [15:0] pkt_q, pkt_d;
  logic        acc;
  logic [31:0] depth;
  logic        in_rng;

  assign s.s_ready = ready_q & ~s.hold;
  assign acc       = s.s_valid & s.s_ready;

  // Depth of the latched target; the address check is unsigned and 32-bit so
  // depths of 65536 or more simply never drop.
  always_comb begin
    depth = 32'(BIAS_DEPTH);
    case (tgt_q)
      2'd1:    depth = 32'(INPUT_DEPTH);
      2'd2:    depth = 32'(WEIGHT_DEPTH);
      default: depth = 32'(BIAS_DEPTH);
    endcase
  end
  assign in_rng = ({16'd0, addr_q} < depth);

  // All state and registered outputs; ready_q comes up one edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      tgt_q     <= 2'd0;
      addr_q    <= 16'd0;
      rem_q     <= 16'd0;
      len_hi_q  <= 8'd0;
      in_addr_q <= 16'd0; wt_addr_q <= 16'd0; bs_addr_q <= 16'd0;
      in_data_q <= 8'd0;  wt_data_q <= 8'd0;  bs_data_q <= 8'd0;
      in_we_q   <= 1'b0;  wt_we_q   <= 1'b0;  bs_we_q   <= 1'b0;
      done_q    <= 1'b0;
      err_t_q   <= 1'b0;
      err_r_q   <= 1'b0;
      pkt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= 1'b1;
      tgt_q     <= tgt_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      len_hi_q  <= len_hi_d;
      in_addr_q <= in_addr_d; wt_addr_q <= wt_addr_d; bs_addr_q <= bs_addr_d;
      in_data_q <= in_data_d; wt_data_q <= wt_data_d; bs_data_q <= bs_data_d;
      in_we_q   <= in_we_d;   wt_we_q   <= wt_we_d;   bs_we_q   <= bs_we_d;
      done_q    <= done_d;
      err_t_q   <= err_t_d;
      err_r_q   <= err_r_d;
      pkt_q     <= pkt_d;
    end
  end

  // Packet parser: next state, write strobes and status pulses.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_hi_d  = len_hi_q;
    in_addr_d = in_addr_q; wt_addr_d = wt_addr_q; bs_addr_d = bs_addr_q;
    in_data_d = in_data_q; wt_data_d = wt_data_q; bs_data_d = bs_data_q;
    in_we_d   = 1'b0; wt_we_d = 1'b0; bs_we_d = 1'b0;
    done_d    = 1'b0;
    err_t_d   = 1'b0;
    err_r_d   = err_r_q;
    pkt_d     = pkt_q;
    if (acc) begin
      case (state_q)
        IDLE: begin
          if (s.s_data >= 8'h01 && s.s_data <= 8'h03) begin
            tgt_d   = s.s_data[1:0];
            err_r_d = 1'b0;
            state_d = A_HI;
          end else begin
            err_t_d = 1'b1;
          end
        end
        A_HI: begin addr_d[15:8] = s.s_data; state_d = A_LO; end
        A_LO: begin addr_d[7:0]  = s.s_data; state_d = L_HI; end
        L_HI: begin len_hi_d     = s.s_data; state_d = L_LO; end
        L_LO: begin
          if ({len_hi_q, s.s_data} == 16'd0) begin
            done_d  = 1'b1;
            pkt_d   = pkt_q + 16'd1;
            state_d = IDLE;
          end else begin
            rem_d   = {len_hi_q, s.s_data};
            state_d = DATA;
          end
        end
        DATA: begin
          if (in_rng) begin
            case (tgt_q)
              2'd1:    begin in_we_d = 1'b1; in_addr_d = addr_q; in_data_d = s.s_data; end
              2'd2:    begin wt_we_d = 1'b1; wt_addr_d = addr_q; wt_data_d = s.s_data; end
              default: begin bs_we_d = 1'b1; bs_addr_d = addr_q; bs_data_d = s.s_data; end
            endcase
          end else begin
            err_r_d = 1'b1;
          end
          addr_d = addr_q + 16'd1;
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            pkt_d   = pkt_q + 16'd1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign input_addr_o  = in_addr_q;
  assign input_data_o  = in_data_q;
  assign input_we_o    = in_we_q;
  assign weight_addr_o = wt_addr_q;
  assign weight_data_o = wt_data_q;
  assign weight_we_o   = wt_we_q;
  assign bias_addr_o   = bs_addr_q;
  assign bias_data_o   = bs_data_q;
  assign bias_we_o     = bs_we_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_target_o  = err_t_q;
  assign err_range_o   = err_r_q;
  assign pkt_count_o   = pkt_q;

endmodule

// File: tb/tb_mlp_host_loader.sv
// Randomized scoreboard bench for mlp_host_loader: a packet-level model
// predicts every write/done/err_target event; a negedge monitor checks them.
module tb_mlp_host_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlp_host_loader_if bus();

  logic [15:0] input_addr, weight_addr, bias_addr, pkt_count;
  logic [7:0]  input_data, weight_data, bias_data;
  logic        input_we, weight_we, bias_we, busy, done, err_target, err_range;

  mlp_host_loader dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave),
    .input_addr_o(input_addr), .input_data_o(input_data), .input_we_o(input_we),
    .weight_addr_o(weight_addr), .weight_data_o(weight_data), .weight_we_o(weight_we),
    .bias_addr_o(bias_addr), .bias_data_o(bias_data), .bias_we_o(bias_we),
    .busy_o(busy), .done_o(done), .err_target_o(err_target),
    .err_range_o(err_range), .pkt_count_o(pkt_count)
  );

  // kind: 0 write, 1 done, 2 err_target
  typedef struct {
    int          kind;
    int          tgt;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] pcnt;
    logic        erng;
  } ev_t;

  ev_t  sb_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [15:0] model_pkt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int depth_of(input int t);
    if (t == 1) return 4096;
    if (t == 2) return 16384;
    return 256;
  endfunction

  // Monitor: every observed event must match the head of the scoreboard and
  // appear exactly one cycle after the byte that caused it was accepted.
  always @(negedge clk) begin
    int   nwe, t;
    ev_t  e;
    int   a;
    logic [15:0] ad;
    logic [7:0]  dt;
    if (rst_n) begin
      nwe = int'(input_we) + int'(weight_we) + int'(bias_we);
      if (nwe > 1) begin
        checks++; errors++;
        $display("FAIL onehot_we: got %0d write strobes, required at most 1", nwe);
      end else if (nwe == 1) begin
        t  = input_we ? 1 : weight_we ? 2 : 3;
        ad = input_we ? input_addr : weight_we ? weight_addr : bias_addr;
        dt = input_we ? input_data : weight_we ? weight_data : bias_data;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected write tgt=%0d addr=%h data=%h", t, ad, dt);
        end else begin
          e = sb_q.pop_front();
          if (e.kind != 0 || e.tgt != t || e.addr != ad || e.data != dt) begin
            errors++;
            $display("FAIL write: got kind=0 tgt=%0d addr=%h data=%h, required kind=%0d tgt=%0d addr=%h data=%h",
                     t, ad, dt, e.kind, e.tgt, e.addr, e.data);
          end
        end
      end
      if (done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL done: unexpected done pulse, pkt_count=%h", pkt_count);
        end else begin
          e = sb_q.pop_front();
          if (e.kind != 1 || pkt_count != e.pcnt || err_range != e.erng || busy) begin
            errors++;
            $display("FAIL done: got pkt_count=%h err_range=%b busy=%b, required kind=%0d pkt_count=%h err_range=%b busy=0",
                     pkt_count, err_range, busy, e.kind, e.pcnt, e.erng);
          end
        end
      end
      if (err_target) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL err_target: unexpected pulse");
        end else begin
          e = sb_q.pop_front();
          if (e.kind != 2) begin
            errors++;
            $display("FAIL err_target: got err_target pulse, required event kind %0d", e.kind);
          end
        end
      end
      if (nwe != 0 || done || err_target) begin
        checks++;
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        if (cyc != a + 1) begin
          errors++;
          $display("FAIL latency: event in cycle %0d, required cycle %0d", cyc, a + 1);
        end
      end
    end
  end

  // mode 0: full rate; 1: random valid gaps; 2: gaps plus hold toggling
  task automatic send_byte(input logic [7:0] b, input bit rec, input int mode);
    bit acc = 0;
    int tries = 0;
    int c = 0;
    while (!acc) begin
      @(negedge clk);
      bus.s_data  = b;
      bus.s_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.hold    = (mode == 2) ? ~bus.hold : 1'b0;
      #1;
      acc = bus.s_valid && bus.s_ready;
      c   = cyc;
      @(posedge clk);
      tries++;
      if (!acc && tries > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: byte %h not accepted in 200 cycles, required acceptance", b);
        break;
      end
    end
    if (acc && rec) acc_q.push_back(c);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.hold    = 1'b0;
  endtask

  // Model: from the packet fields alone, list the writes that must land and
  // the done that closes the packet.
  task automatic send_pkt(input int tgt, input logic [15:0] addr, input int len, input int mode);
    logic [7:0]  pay[$];
    logic [15:0] a;
    bit          drop = 0;
    bit          inr;
    ev_t         e;
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    for (int i = 0; i < len; i++) begin
      a = addr + 16'(i);
      if (int'(a) < depth_of(tgt)) begin
        e = '{kind: 0, tgt: tgt, addr: a, data: pay[i], pcnt: 16'd0, erng: 1'b0};
        sb_q.push_back(e);
      end else drop = 1;
    end
    model_pkt = model_pkt + 16'd1;
    e = '{kind: 1, tgt: tgt, addr: 16'd0, data: 8'd0, pcnt: model_pkt, erng: drop};
    sb_q.push_back(e);
    send_byte(8'(tgt), 0, mode);
    send_byte(addr[15:8], 0, mode);
    send_byte(addr[7:0], 0, mode);
    send_byte(8'(len >> 8), 0, mode);
    send_byte(8'(len), len == 0, mode);
    for (int i = 0; i < len; i++) begin
      a   = addr + 16'(i);
      inr = int'(a) < depth_of(tgt);
      send_byte(pay[i], inr || (i == len - 1), mode);
    end
  endtask

  task automatic send_illegal(input logic [7:0] b, input int mode);
    ev_t e;
    e = '{kind: 2, tgt: 0, addr: 16'd0, data: 8'd0, pcnt: 16'd0, erng: 1'b0};
    sb_q.push_back(e);
    send_byte(b, 1, mode);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", sb_q.size());
      sb_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, {31'd0, bus.s_ready}, 32'd0);
    chk({nm, "_we"}, {29'd0, input_we, weight_we, bias_we}, 32'd0);
    chk({nm, "_addr"}, {input_addr, weight_addr | bias_addr}, 32'd0);
    chk({nm, "_data"}, {8'd0, input_data, weight_data, bias_data}, 32'd0);
    chk({nm, "_status"}, {28'd0, busy, done, err_target, err_range}, 32'd0);
    chk({nm, "_pkt"}, {16'd0, pkt_count}, 32'd0);
  endtask

  initial begin
    ev_t e;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.hold    = 1'b0;
    #3;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: input load 01 00 10 00 03 AA BB CC
    begin
      ev_t w;
      logic [7:0] d[3];
      d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC;
      for (int i = 0; i < 3; i++) begin
        w = '{kind: 0, tgt: 1, addr: 16'h0010 + 16'(i), data: d[i], pcnt: 16'd0, erng: 1'b0};
        sb_q.push_back(w);
      end
      model_pkt = model_pkt + 16'd1;
      w = '{kind: 1, tgt: 1, addr: 16'd0, data: 8'd0, pcnt: model_pkt, erng: 1'b0};
      sb_q.push_back(w);
      send_byte(8'h01, 0, 0); send_byte(8'h00, 0, 0); send_byte(8'h10, 0, 0);
      send_byte(8'h00, 0, 0); send_byte(8'h03, 0, 0);
      for (int i = 0; i < 3; i++) send_byte(d[i], 1, 0);
      go_idle();
      drain();
      chk("pkt_after_load", {16'd0, pkt_count}, 32'd1);
    end

    // Bias range: writes at 0xFE, 0xFF only; err_range sticky afterwards
    send_pkt(3, 16'h00FE, 4, 0);
    go_idle();
    drain();
    chk("err_range_sticky", {31'd0, err_range}, 32'd1);

    // Illegal target then zero-length weight packet (clears err_range)
    send_illegal(8'h07, 0);
    send_pkt(2, 16'h1234, 0, 0);
    go_idle();
    drain();
    chk("err_range_cleared", {31'd0, err_range}, 32'd0);
    send_illegal(8'h00, 1);
    send_illegal(8'hFF, 1);

    // Backpressure: weight 8 bytes with hold toggling and gaps
    send_pkt(2, 16'h0200, 8, 2);
    go_idle();
    drain();

    // Back-to-back input packets at full rate, then address wrap
    send_pkt(1, 16'h0100, 3, 0);
    send_pkt(1, 16'h0200, 2, 0);
    send_pkt(1, 16'hFFFF, 2, 0);
    go_idle();
    drain();

    // Randomized packets around the depth boundaries
    for (int k = 0; k < 20; k++) begin
      int t;
      logic [15:0] a;
      t = int'($urandom_range(1, 3));
      a = 16'(depth_of(t) - int'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) a = 16'($urandom);
      if ($urandom_range(0, 5) == 0) send_illegal(8'($urandom_range(4, 255)), 1);
      send_pkt(t, a, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
    end
    go_idle();
    drain();

    // Reset mid-DATA after 2 of 5 payload bytes
    for (int i = 0; i < 2; i++) begin
      e = '{kind: 0, tgt: 2, addr: 16'h0040 + 16'(i), data: 8'h50 + 8'(i), pcnt: 16'd0, erng: 1'b0};
      sb_q.push_back(e);
    end
    send_byte(8'h02, 0, 0); send_byte(8'h00, 0, 0); send_byte(8'h40, 0, 0);
    send_byte(8'h00, 0, 0); send_byte(8'h05, 0, 0);
    send_byte(8'h50, 1, 0); send_byte(8'h51, 1, 0);
    go_idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_writes: %0d writes missing, required 0", sb_q.size());
      sb_q.delete();
    end
    acc_q.delete();
    model_pkt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    send_pkt(1, 16'h0020, 3, 1);
    go_idle();
    drain();
    chk("pkt_after_reset", {16'd0, pkt_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
